// File: rtl/sfx_sequencer.sv
// sfx_sequencer: shares one piezo between a held color tone and four-note
// event jingles. Event pulses are latched as pending bits, jingles are played
// in fixed priority (LOSE > WIN > HS > START) ahead of the tone, and the
// square wave is generated locally from a per-pitch half-period.
//
// state    | meaning
// S_IDLE   | silent, nothing requested
// S_TONE   | color tone sounding while TONE_ENA is held
// S_JINGLE | a jingle is playing (BUSY high)
module sfx_sequencer #(
  parameter int HALF_BASE  = 2500,
  parameter int NOTE_TICKS = 1_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TONE_ENA,
  input  logic [1:0] TONE_SEL,
  input  logic       EVT_START,
  input  logic       EVT_WIN,
  input  logic       EVT_LOSE,
  input  logic       EVT_HS,
  output logic       SPKR,
  output logic       BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_TONE, S_JINGLE} state_t;

  // Jingle codes double as pending-bit indices.
  localparam logic [1:0] J_START = 2'd0;
  localparam logic [1:0] J_WIN   = 2'd1;
  localparam logic [1:0] J_LOSE  = 2'd2;
  localparam logic [1:0] J_HS    = 2'd3;

  localparam logic [23:0] TICK_LAST = 24'(NOTE_TICKS - 1);
  localparam logic [15:0] HB        = 16'(HALF_BASE);

  state_t      state_q;
  logic [3:0]  pend_q;
  logic [15:0] phase_q;
  logic [23:0] tick_q;
  logic [1:0]  unit_q;
  logic [1:0]  note_q;
  logic [1:0]  jsel_q;
  logic [1:0]  tone_sel_q;
  logic        spkr_q;
  logic        busy_q;

  logic [3:0]  pend_set;
  logic        pend_any;
  logic [1:0]  jsel_d;
  logic [3:0]  jsel_onehot;
  logic [2:0]  rom_pitch;
  logic [1:0]  rom_dur_m1;
  logic [2:0]  cur_pitch;
  logic [15:0] half_m1;
  logic        note_end;
  logic        jingle_done;
  logic        arbitrate;
  logic [15:0] phase_d;
  logic        spkr_d;

  // Pending latch merged with this cycle's pulses, and priority pick.
  always_comb begin
    pend_set = pend_q | {EVT_HS, EVT_LOSE, EVT_WIN, EVT_START};
    pend_any = |pend_set;
    if (pend_set[J_LOSE])      jsel_d = J_LOSE;
    else if (pend_set[J_WIN])  jsel_d = J_WIN;
    else if (pend_set[J_HS])   jsel_d = J_HS;
    else                       jsel_d = J_START;
    jsel_onehot = 4'b0001 << jsel_d;
  end

  // Jingle ROM: {pitch, duration-1} per note; pitch 0 is a rest.
  always_comb begin
    rom_pitch  = 3'd0;
    rom_dur_m1 = 2'd0;
    case ({jsel_q, note_q})
      4'b00_00: begin rom_pitch = 3'd1; rom_dur_m1 = 2'd0; end
      4'b00_01: begin rom_pitch = 3'd2; rom_dur_m1 = 2'd0; end
      4'b00_10: begin rom_pitch = 3'd3; rom_dur_m1 = 2'd0; end
      4'b00_11: begin rom_pitch = 3'd4; rom_dur_m1 = 2'd0; end
      4'b01_00: begin rom_pitch = 3'd4; rom_dur_m1 = 2'd0; end
      4'b01_01: begin rom_pitch = 3'd5; rom_dur_m1 = 2'd0; end
      4'b01_10: begin rom_pitch = 3'd6; rom_dur_m1 = 2'd0; end
      4'b01_11: begin rom_pitch = 3'd7; rom_dur_m1 = 2'd2; end
      4'b10_00: begin rom_pitch = 3'd3; rom_dur_m1 = 2'd1; end
      4'b10_01: begin rom_pitch = 3'd2; rom_dur_m1 = 2'd1; end
      4'b10_10: begin rom_pitch = 3'd1; rom_dur_m1 = 2'd3; end
      4'b10_11: begin rom_pitch = 3'd0; rom_dur_m1 = 2'd0; end
      4'b11_00: begin rom_pitch = 3'd5; rom_dur_m1 = 2'd0; end
      4'b11_01: begin rom_pitch = 3'd7; rom_dur_m1 = 2'd0; end
      4'b11_10: begin rom_pitch = 3'd5; rom_dur_m1 = 2'd0; end
      default:  begin rom_pitch = 3'd7; rom_dur_m1 = 2'd0; end
    endcase
  end

  // Note timing and square-wave step for whatever is currently sounding.
  always_comb begin
    cur_pitch   = (state_q == S_JINGLE) ? rom_pitch : ({1'b0, tone_sel_q} + 3'd1);
    half_m1     = HB * {12'd0, 4'd9 - {1'b0, cur_pitch}} - 16'd1;
    note_end    = (tick_q == TICK_LAST) && (unit_q == rom_dur_m1);
    jingle_done = (state_q == S_JINGLE) && note_end && (note_q == 2'd3);
    arbitrate   = (state_q != S_JINGLE) || jingle_done;
    if (cur_pitch == 3'd0) begin
      phase_d = 16'd0;
      spkr_d  = 1'b0;
    end else if (phase_q == half_m1) begin
      phase_d = 16'd0;
      spkr_d  = ~spkr_q;
    end else begin
      phase_d = phase_q + 16'd1;
      spkr_d  = spkr_q;
    end
  end

  // Sequencer FSM with registered SPKR/BUSY; a jingle end re-arbitrates
  // in the same cycle so chained jingles have no gap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      pend_q     <= 4'd0;
      phase_q    <= 16'd0;
      tick_q     <= 24'd0;
      unit_q     <= 2'd0;
      note_q     <= 2'd0;
      jsel_q     <= 2'd0;
      tone_sel_q <= 2'd0;
      spkr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pend_q <= pend_set;
      if (arbitrate) begin
        if (pend_any) begin
          state_q <= S_JINGLE;
          busy_q  <= 1'b1;
          jsel_q  <= jsel_d;
          note_q  <= 2'd0;
          tick_q  <= 24'd0;
          unit_q  <= 2'd0;
          phase_q <= 16'd0;
          spkr_q  <= 1'b0;
          pend_q  <= pend_set & ~jsel_onehot;
        end else if (TONE_ENA) begin
          state_q <= S_TONE;
          busy_q  <= 1'b0;
          if ((state_q != S_TONE) || (TONE_SEL != tone_sel_q)) begin
            tone_sel_q <= TONE_SEL;
            phase_q    <= 16'd0;
            spkr_q     <= 1'b0;
          end else begin
            phase_q <= phase_d;
            spkr_q  <= spkr_d;
          end
        end else begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          phase_q <= 16'd0;
          spkr_q  <= 1'b0;
        end
      end else if (note_end) begin
        note_q  <= note_q + 2'd1;
        tick_q  <= 24'd0;
        unit_q  <= 2'd0;
        phase_q <= 16'd0;
        spkr_q  <= 1'b0;
      end else begin
        if (tick_q == TICK_LAST) begin
          tick_q <= 24'd0;
          unit_q <= unit_q + 2'd1;
        end else begin
          tick_q <= tick_q + 24'd1;
        end
        phase_q <= phase_d;
        spkr_q  <= spkr_d;
      end
    end
  end

  assign SPKR = spkr_q;
  assign BUSY = busy_q;

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Speaker sound-effect sequencer and arbiter for the game. It shares one piezo output between two kinds of request: a continuous color tone, held while the game controller displays or accepts a color, and short four-note jingles for start, win, lose and new-high-score events. It latches event pulses so none is lost, plays jingles in a fixed priority order ahead of the color tone, and generates the square wave itself.

## Interface
- HALF_BASE, default 2500: cycles per half-period unit. Half-period for pitch p (1..7) = HALF_BASE*(9-p) cycles. HALF_BASE*8 must fit in 16 bits.
- NOTE_TICKS, default 1_000_000: cycles per duration unit. Must fit in 24 bits and be ≥1.
- CLK  in  1  system clock; everything is on its rising edge
- RST  in  1  synchronous, active-high reset
- TONE_ENA  in  1  level; request the color tone (driven from controller OUT_ENA)
- TONE_SEL  in  2  color index; tone pitch = TONE_SEL+1 (1..4)
- EVT_START, EVT_WIN, EVT_LOSE, EVT_HS  in  1 each  single-cycle event pulses
- SPKR  out  1  square-wave speaker drive, registered
- BUSY  out  1  high exactly while the state is S_JINGLE, registered

## Operation
- States:
  - S_IDLE: SPKR held 0.
  - S_TONE: plays the color tone.
  - S_JINGLE: plays the selected jingle.
- Pending bits: each EVT_* pulse sets its own bit, which stays set until that jingle starts.
  - Setting an already-set bit is a no-op, so duplicates collapse.
  - A pulse for the jingle currently playing re-sets its bit; that jingle replays afterward.
- Priority among pending jingles: LOSE > WIN > HS > START. Starting a jingle clears only its own bit.
- Any pending bit beats the tone. From S_IDLE or S_TONE, any pending bit → S_JINGLE, so a tone is preempted.
- S_IDLE → S_TONE when TONE_ENA=1 and nothing is pending.
- S_TONE → S_IDLE when TONE_ENA=0.
- TONE_SEL change while in S_TONE: the new pitch applies next cycle, with the phase counter and SPKR reset.
- End of jingle:
  - next pending jingle, if any, with no idle gap;
  - else S_TONE if TONE_ENA=1;
  - else S_IDLE.
- Jingle ROM: four notes each, each note {pitch 3b, duration 1..4 units}; pitch 0 = rest (SPKR 0, phase counter held at 0).
  - START: 1,2,3,4; durations 1,1,1,1.
  - WIN: 4,5,6,7; durations 1,1,1,3.
  - LOSE: 3,2,1,0; durations 2,2,4,1.
  - HS: 5,7,5,7; durations 1,1,1,1.
- Counters:
  - 16-bit phase counter.
  - 24-bit tick counter (0..NOTE_TICKS-1).
  - 2-bit unit counter.
  - 2-bit note index.
  - 2-bit jingle select.
- Square wave: on entering any sounding note or tone, the phase counter and SPKR are 0. When the phase counter reaches half-1, SPKR toggles and the counter wraps to 0.

## Timing
- Reset values: SPKR=0, BUSY=0, state S_IDLE, all pending bits 0, all counters 0. Reset mid-jingle or mid-tone aborts immediately and clears pending bits, with no residual sound.
- Event pulse sampled at edge k → S_JINGLE and BUSY=1 from edge k+1. Note 0 starts at k+1.
- An event pulse coinciding with end of jingle is latched and participates in that cycle's priority selection.
- Note length = duration × NOTE_TICKS cycles exactly. A note boundary resets the phase counter and SPKR to 0.
- Jingle lengths in units: START 4, WIN 6, LOSE 9, HS 4.
- TONE_ENA rise sampled at edge k → S_TONE from k+1. The first SPKR rise comes half cycles later; period = 2×half.
- TONE_ENA fall sampled at edge k → SPKR=0 and S_IDLE from k+1.
- Simultaneous event and TONE_ENA rise: the jingle wins; the tone follows if TONE_ENA is still high.

## Test plan
All scenarios use HALF_BASE=2, NOTE_TICKS=20.
- Reset: assert RST for 3 cycles with TONE_ENA=1 and EVT_WIN pulsed → SPKR=0, BUSY=0 throughout, and no jingle after release.
- Tone: TONE_SEL=2, TONE_ENA high → SPKR first rises 12 cycles after S_TONE entry, period 24; TONE_ENA low → SPKR=0 next cycle.
- START pulse → BUSY high for exactly 80 cycles; half-periods 16, 14, 12, 10 per 20-cycle note; then S_IDLE.
- EVT_WIN and EVT_HS in the same cycle → WIN plays (120 cycles), then HS (80 cycles); BUSY stays high continuously for 200 cycles.
- TONE_ENA held, EVT_LOSE pulsed mid-tone → tone cut next cycle. LOSE plays 180 cycles, with the last 20 cycles silent (rest note). The tone then resumes with its phase reset.
- EVT_START pulsed 3 times during one START jingle → exactly one replay, i.e. 160 BUSY cycles total. RST mid-replay → SPKR=0 and BUSY=0 next cycle.
